sram_port_arbiter: RTL and testbench

- Shares one port of a single-port SRAM macro among `NumReq` requesters, using round-robin arbitration.
- Tracks each read in a fixed-latency pipeline and returns the data to the requester that issued it.
- An optional lock lets one requester hold the port for a burst.
- Sits between cluster masters (cores, DMA) and one SRAM bank.

---
 rtl/sram_port_arbiter_pkg.sv | 14 +
 rtl/sram_port_arbiter_rr.sv | 41 ++++
 rtl/sram_port_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// rtl/sram_port_arbiter_pkg.sv - shared types and helpers for the SRAM port arbiter
package sram_port_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Width of an index able to address n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_rr.sv
// rtl/sram_port_arbiter_rr.sv - combinational round-robin picker
//
// Searches req & mask starting at ptr and wrapping modulo NumReq; the first
// active requester wins.
//   req  : request vector
//   ptr  : index with highest priority this cycle
//   mask : requesters allowed to win
//   gnt  : one-hot grant, zero when nobody qualifies
//   idx  : index of the winner (0 when nobody qualifies)
module sram_port_arbiter_rr
    import sram_port_arbiter_pkg::*;
#(
    parameter int NumReq = 4,
    localparam int IdxWidth = idx_width(NumReq)
) (
    input  logic [NumReq-1:0]   req,
    input  logic [IdxWidth-1:0] ptr,
    input  logic [NumReq-1:0]   mask,
    output logic [NumReq-1:0]   gnt,
    output logic [IdxWidth-1:0] idx
);

    logic        found;
    int unsigned cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < NumReq; i++) begin
            cand = (int'(ptr) + i) % NumReq;
            if (!found && req[cand] && mask[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IdxWidth'(cand);
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - round-robin arbiter sharing one single-port SRAM
//
// Grants one of NumReq requesters per cycle onto the SRAM port, then returns
// an rvalid (plus read data for reads) to that requester Latency cycles later.
// Optional burst lock is built when SRAM_PORT_ARBITER_LOCK_EN is defined.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   req_i/we_i/lock_i      : per-requester request, write enable, lock request
//   addr_i/wdata_i/be_i    : per-requester payload, requester k at slice k
//   gnt_o                  : one-hot grant (combinational)
//   rvalid_o, rdata_o      : per-requester response valid, shared read data
//   sram_req_o .. sram_be_o: SRAM port drive, zero when nothing is granted
//   sram_rdata_i           : SRAM read data, Latency cycles after the read
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int NumReq    = 4,
    parameter int NumWords  = 1024,
    parameter int DataWidth = 32,
    parameter int ByteWidth = 8,
    parameter int Latency   = 1,
    parameter int MaxLock   = 16,
    localparam int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NumReq-1:0]           req_i,
    input  logic [NumReq-1:0]           we_i,
    input  logic [NumReq-1:0]           lock_i,
    input  logic [NumReq*AddrWidth-1:0] addr_i,
    input  logic [NumReq*DataWidth-1:0] wdata_i,
    input  logic [NumReq*BeWidth-1:0]   be_i,
    output logic [NumReq-1:0]           gnt_o,
    output logic [NumReq-1:0]           rvalid_o,
    output logic [DataWidth-1:0]        rdata_o,
    output logic                        sram_req_o,
    output logic                        sram_we_o,
    output logic [AddrWidth-1:0]        sram_addr_o,
    output logic [DataWidth-1:0]        sram_wdata_o,
    output logic [BeWidth-1:0]          sram_be_o,
    input  logic [DataWidth-1:0]        sram_rdata_i
);

    localparam int IdxWidth = idx_width(NumReq);
    localparam int CntWidth = idx_width(MaxLock);

    logic [IdxWidth-1:0] rr_q, rr_d;
    logic [NumReq-1:0]   mask;
    logic [NumReq-1:0]   pick_gnt;
    logic [IdxWidth-1:0] pick_idx;
    logic                any_gnt;

    // Response pipeline: stage 0 is the one presented on rvalid_o this cycle.
    logic [Latency-1:0]               pipe_valid;
    logic [Latency-1:0]               pipe_we;
    logic [Latency-1:0][IdxWidth-1:0] pipe_idx;

    function automatic logic [IdxWidth-1:0] inc_wrap(input logic [IdxWidth-1:0] i);
        if (i == IdxWidth'(NumReq - 1)) begin
            return '0;
        end
        return i + IdxWidth'(1);
    endfunction

    sram_port_arbiter_rr #(
        .NumReq(NumReq)
    ) u_rr (
        .req (req_i),
        .ptr (rr_q),
        .mask(mask),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign gnt_o      = rst_i ? '0 : pick_gnt;
    assign any_gnt    = |gnt_o;
    assign sram_req_o = any_gnt;

`ifdef SRAM_PORT_ARBITER_LOCK_EN
    arb_state_e          state_q, state_d;
    logic [IdxWidth-1:0] owner_q, owner_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                lock_expire;

    // The last LOCKED cycle grants nobody; the port is released next cycle.
    assign lock_expire = (state_q == LOCKED) && (cnt_q == CntWidth'(MaxLock - 1));

    always_comb begin
        mask = '1;
        if (state_q == LOCKED) begin
            mask = lock_expire ? '0 : (NumReq'(1) << owner_q);
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_gnt && lock_i[pick_idx]) begin
                    state_d = LOCKED;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                end
            end
            LOCKED: begin
                if (lock_expire) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (any_gnt && !lock_i[owner_q]) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // A timed-out lock hands priority to the requester after the owner.
    always_comb begin
        rr_d = rr_q;
        if (any_gnt) begin
            rr_d = inc_wrap(pick_idx);
        end else if (lock_expire) begin
            rr_d = inc_wrap(owner_q);
        end
    end
`else
    logic unused_lock;

    assign unused_lock = ^lock_i;
    assign mask        = '1;

    always_comb begin
        rr_d = rr_q;
        if (any_gnt) begin
            rr_d = inc_wrap(pick_idx);
        end
    end
`endif

    always_comb begin
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (gnt_o[i]) begin
                sram_we_o    = we_i[i];
                sram_addr_o  = addr_i[i*AddrWidth +: AddrWidth];
                sram_wdata_o = wdata_i[i*DataWidth +: DataWidth];
                sram_be_o    = be_i[i*BeWidth +: BeWidth];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            pipe_valid <= '0;
            pipe_we    <= '0;
            pipe_idx   <= '0;
        end else begin
            rr_q <= rr_d;
            for (int s = 0; s < Latency - 1; s++) begin
                pipe_valid[s] <= pipe_valid[s+1];
                pipe_we[s]    <= pipe_we[s+1];
                pipe_idx[s]   <= pipe_idx[s+1];
            end
            pipe_valid[Latency-1] <= any_gnt;
            pipe_we[Latency-1]    <= sram_we_o;
            pipe_idx[Latency-1]   <= pick_idx;
        end
    end

    // Write acknowledgements carry no data, so rdata_o stays 0 for them.
    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        if (pipe_valid[0] && !rst_i) begin
            rvalid_o[pipe_idx[0]] = 1'b1;
            if (!pipe_we[0]) begin
                rdata_o = sram_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;

    localparam int NR      = 4;
    localparam int NWORDS  = 1024;
    localparam int AW      = 10;
    localparam int DW      = 32;
    localparam int BW      = 4;
    localparam int LAT     = 3;
    localparam int MAXLOCK = 4;

    logic clk = 1'b0;
    logic rst;
    logic [NR-1:0]          req, we, lock;
    logic [NR-1:0][AW-1:0]  addr;
    logic [NR-1:0][DW-1:0]  wdata;
    logic [NR-1:0][BW-1:0]  be;
    logic [NR-1:0]          gnt, rvalid;
    logic [DW-1:0]          rdata;
    logic                   sram_req, sram_we;
    logic [AW-1:0]          sram_addr;
    logic [DW-1:0]          sram_wdata;
    logic [BW-1:0]          sram_be;
    logic [DW-1:0]          sram_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int            due;
        int            idx;
        logic [DW-1:0] data;
    } sb_t;
    sb_t sb[$];

    logic [DW-1:0] mem [NWORDS] = '{default: '0};
    logic [DW-1:0] ref_mem [NWORDS] = '{default: '0};
    logic [LAT-1:0][DW-1:0] rd_pipe = '0;

    int m_rr = 0;
`ifdef SRAM_PORT_ARBITER_LOCK_EN
    bit m_locked = 0;
    int m_owner = 0;
    int m_cnt = 0;
`endif

    sram_port_arbiter #(
        .NumReq(NR), .NumWords(NWORDS), .DataWidth(DW), .ByteWidth(8),
        .Latency(LAT), .MaxLock(MAXLOCK)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .lock_i(lock),
        .addr_i(addr), .wdata_i(wdata), .be_i(be), .gnt_o(gnt),
        .rvalid_o(rvalid), .rdata_o(rdata), .sram_req_o(sram_req),
        .sram_we_o(sram_we), .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata),
        .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM macro model with LAT-cycle read latency.
    always @(posedge clk) begin
        for (int s = 0; s < LAT - 1; s++) rd_pipe[s] <= rd_pipe[s+1];
        rd_pipe[LAT-1] <= (sram_req && !sram_we) ? mem[sram_addr] : '0;
        if (sram_req && sram_we) begin
            for (int b = 0; b < BW; b++) begin
                if (sram_be[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
            end
        end
    end
    assign sram_rdata = rd_pipe[0];

    // Response monitor: pops expected responses as they fall due.
    always @(negedge clk) begin
        logic [NR-1:0] ev;
        logic [DW-1:0] ed;
        ev = '0;
        ed = '0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                ev[sb[i].idx] = 1'b1;
                ed = sb[i].data;
                sb.delete(i);
            end else if (sb[i].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL late_response cyc=%0d idx=%0d due=%0d", cyc, sb[i].idx, sb[i].due);
                sb.delete(i);
            end
        end
        checks++;
        if (rvalid !== ev) begin
            errors++;
            $display("FAIL rvalid cyc=%0d got=%b exp=%b", cyc, rvalid, ev);
        end
        if (ev != '0) begin
            checks++;
            if (rdata !== ed) begin
                errors++;
                $display("FAIL rdata cyc=%0d got=%h exp=%h", cyc, rdata, ed);
            end
        end
    end

    task automatic model_reset();
        m_rr = 0;
        sb.delete();
`ifdef SRAM_PORT_ARBITER_LOCK_EN
        m_locked = 0;
        m_owner = 0;
        m_cnt = 0;
`endif
    endtask

    // One clock of the reference model: predicts and checks grant and SRAM drive,
    // pushes the expected response, advances to just after the next posedge.
    task automatic step();
        logic [NR-1:0] exp_gnt, msk;
        logic [1+AW+DW+BW-1:0] exp_pay;
        int k;
        bit found;
        sb_t e;
        @(negedge clk);
        exp_gnt = '0;
        msk = '1;
        found = 0;
        k = 0;
`ifdef SRAM_PORT_ARBITER_LOCK_EN
        if (m_locked) msk = (m_cnt == MAXLOCK - 1) ? '0 : (NR'(1) << m_owner);
`endif
        for (int i = 0; i < NR; i++) begin
            int j = (m_rr + i) % NR;
            if (!found && req[j] && msk[j]) begin
                found = 1;
                k = j;
            end
        end
        if (found) exp_gnt[k] = 1'b1;
        exp_pay = found ? {we[k], addr[k], wdata[k], be[k]} : '0;
        checks++;
        if (gnt !== exp_gnt) begin
            errors++;
            $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, gnt, exp_gnt);
        end
        checks++;
        if (sram_req !== found) begin
            errors++;
            $display("FAIL sram_req cyc=%0d got=%b exp=%b", cyc, sram_req, found);
        end
        checks++;
        if ({sram_we, sram_addr, sram_wdata, sram_be} !== exp_pay) begin
            errors++;
            $display("FAIL sram_payload cyc=%0d got=%h exp=%h", cyc,
                     {sram_we, sram_addr, sram_wdata, sram_be}, exp_pay);
        end
        if (found) begin
            e.due = cyc + LAT;
            e.idx = k;
            if (we[k]) begin
                e.data = '0;
                for (int b = 0; b < BW; b++) begin
                    if (be[k][b]) ref_mem[addr[k]][b*8 +: 8] = wdata[k][b*8 +: 8];
                end
            end else begin
                e.data = ref_mem[addr[k]];
            end
            sb.push_back(e);
            m_rr = (k + 1) % NR;
        end
`ifdef SRAM_PORT_ARBITER_LOCK_EN
        if (!m_locked) begin
            if (found && lock[k]) begin
                m_locked = 1;
                m_owner = k;
                m_cnt = 0;
            end
        end else if (m_cnt == MAXLOCK - 1) begin
            m_locked = 0;
            m_cnt = 0;
            m_rr = (m_owner + 1) % NR;
        end else if (found && !lock[k]) begin
            m_locked = 0;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [NR-1:0] r, input logic [NR-1:0] w, input logic [NR-1:0] l);
        req = r;
        we = w;
        lock = l;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_req('1, '1, '0);
        for (int i = 0; i < NR; i++) begin
            addr[i] = AW'(i + 1);
            wdata[i] = 32'hA5A5_0000 + i;
            be[i] = '1;
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (gnt !== '0) begin errors++; $display("FAIL reset_gnt got=%b exp=0", gnt); end
            checks++;
            if (sram_req !== 1'b0) begin errors++; $display("FAIL reset_sram_req got=%b exp=0", sram_req); end
            checks++;
            if ({sram_we, sram_addr, sram_wdata, sram_be} !== '0) begin
                errors++;
                $display("FAIL reset_sram_payload got=%h exp=0", {sram_we, sram_addr, sram_wdata, sram_be});
            end
            checks++;
            if (rdata !== '0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_req('0, '0, '0);
        model_reset();
    endtask

    task automatic test_round_robin();
        set_req(4'b1111, 4'b0000, 4'b0000);
        for (int i = 0; i < NR; i++) addr[i] = AW'(100 + i);
        repeat (8) step();
        set_req('0, '0, '0);
    endtask

    task automatic test_byte_enable();
        set_req(4'b0100, 4'b0100, 4'b0000);
        addr[2] = AW'(5);
        wdata[2] = 32'hDEADBEEF;
        be[2] = 4'b0101;
        step();
        set_req(4'b0001, 4'b0000, 4'b0000);
        addr[0] = AW'(5);
        step();
        set_req('0, '0, '0);
        repeat (LAT - 1) step();
        @(negedge clk);
        checks++;
        if (rvalid[0] !== 1'b1 || rdata !== 32'h00AD00EF) begin
            errors++;
            $display("FAIL byte_enable_read rvalid0=%b rdata=%h exp_rdata=00ad00ef", rvalid[0], rdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        set_req(4'b1000, 4'b1000, 4'b0000);
        addr[3] = AW'(7);
        wdata[3] = 32'h1234_5678;
        be[3] = 4'b1111;
        step();
        set_req(4'b0010, 4'b0000, 4'b0000);
        addr[1] = AW'(5);
        step();
        set_req(4'b1000, 4'b0000, 4'b0000);
        step();
        set_req('0, '0, '0);
        repeat (LAT + 1) step();
    endtask

    task automatic test_idle();
        set_req(4'b0011, 4'b0000, 4'b0000);
        step();
        set_req('0, '0, '0);
        repeat (3) step();
        set_req(4'b1111, 4'b0000, 4'b0000);
        step();
        set_req('0, '0, '0);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 40; n++) begin
            set_req(NR'($urandom_range(15)), NR'($urandom_range(15)), '0);
            for (int i = 0; i < NR; i++) begin
                addr[i] = AW'($urandom_range(15) + 16);
                wdata[i] = $urandom;
                be[i] = BW'($urandom_range(15));
            end
            step();
        end
        set_req('0, '0, '0);
        repeat (LAT + 1) step();
    endtask

    task automatic test_reset_in_flight();
        set_req(4'b1000, 4'b0000, 4'b0000);
        addr[3] = AW'(7);
        step();
        set_req(4'b0010, 4'b0000, 4'b0000);
        addr[1] = AW'(5);
        step();
        rst = 1'b1;
        set_req(4'b1111, 4'b0000, 4'b0000);
        model_reset();
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (gnt !== '0) begin errors++; $display("FAIL inflight_reset_gnt got=%b exp=0", gnt); end
            @(posedge clk);
        end
        #1;
        rst = 1'b0;
        set_req('0, '0, '0);
        repeat (LAT + 1) step();
        set_req(4'b1111, 4'b0000, 4'b0000);
        step();
        set_req('0, '0, '0);
    endtask

    task automatic test_lock();
        addr[0] = AW'(5);
        addr[1] = AW'(7);
        set_req(4'b0010, 4'b0000, 4'b0010);
        step();
        set_req(4'b0011, 4'b0000, 4'b0010);
        repeat (2) step();
        set_req(4'b0011, 4'b0000, 4'b0000);
        repeat (2) step();
        set_req(4'b0010, 4'b0000, 4'b0010);
        step();
        set_req(4'b0011, 4'b0000, 4'b0010);
        repeat (6) step();
        set_req('0, '0, '0);
        repeat (MAXLOCK + LAT + 1) step();
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        we = '0;
        lock = '0;
        addr = '0;
        wdata = '0;
        be = '0;
        test_reset();
        test_round_robin();
        test_byte_enable();
        test_latency();
        test_idle();
        test_back_to_back();
        test_reset_in_flight();
        test_lock();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
